// File: rtl/de_morgan_2_checker.sv
`default_nettype none
// ============================================================================
//  Module      : de_morgan_2_checker
//  Description : Response checker for a 2-input De Morgan gate. Compares the
//                gate output against a NAND or NOR reference on each valid
//                sample, tracks coverage of the four input combinations and
//                latches a sticky pass/fail verdict.
//  Revision    : 1.0 - initial release
// ============================================================================
module de_morgan_2_checker #(
    parameter int FUNC   = 0,
    parameter int REPEAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_c,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [3:0]       coverage,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2:0]       fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_REPEAT  = CNT_W'(REPEAT);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_coverage;
    logic [3:0]       w_cov_next;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [2:0]       r_fail_vec;

    logic       w_exp;
    logic       w_mismatch;
    logic       w_sample;
    logic [1:0] w_sel;

    // A sample counts only in RUN and only when no restart is requested,
    // so the sample coinciding with a start pulse is discarded.
    assign w_exp      = (FUNC != 0) ? ~(in_a | in_b) : ~(in_a & in_b);
    assign w_mismatch = (in_c != w_exp);
    assign w_sample   = (r_state == ST_RUN) && in_valid && !start;
    assign w_sel      = {in_a, in_b};

    // One saturating hit counter per input combination {a,b}
    for (genvar gi = 0; gi < 4; gi++) begin : g_hit
        logic [CNT_W-1:0] r_hit;
        logic [CNT_W-1:0] w_hit_next;

        assign w_hit_next = start ? '0 :
                            (w_sample && (w_sel == 2'(gi)) && (r_hit != C_CNT_MAX)) ?
                            r_hit + 1'b1 : r_hit;
        assign w_cov_next[gi] = (w_hit_next >= C_REPEAT);

        // Hit counter register; cleared by reset or start
        always_ff @(posedge clk) begin
            if (rst) r_hit <= '0;
            else     r_hit <= w_hit_next;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic: mismatch takes priority over coverage completion
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN: begin
                if (start)
                    w_state_next = ST_RUN;
                else if (w_sample && w_mismatch)
                    w_state_next = ST_FAIL;
                else if (w_sample && (&w_cov_next))
                    w_state_next = ST_PASS;
            end
            ST_PASS: if (start) w_state_next = ST_RUN;
            ST_FAIL: if (start) w_state_next = ST_RUN;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: saturating counters, coverage and first-mismatch capture
    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_coverage <= '0;
            r_vec_cnt  <= '0;
            r_err_cnt  <= '0;
            r_fail_vec <= '0;
        end else begin
            r_coverage <= w_cov_next;
            if (w_sample && (r_vec_cnt != C_CNT_MAX))
                r_vec_cnt <= r_vec_cnt + 1'b1;
            if (w_sample && w_mismatch) begin
                if (r_err_cnt != C_CNT_MAX)
                    r_err_cnt <= r_err_cnt + 1'b1;
                // Any mismatch in RUN is the first one: it leaves RUN at once
                r_fail_vec <= {in_a, in_b, in_c};
            end
        end
    end

    assign busy     = (r_state == ST_RUN);
    assign pass     = (r_state == ST_PASS);
    assign fail     = (r_state == ST_FAIL);
    assign coverage = r_coverage;
    assign vec_cnt  = r_vec_cnt;
    assign err_cnt  = r_err_cnt;
    assign fail_vec = r_fail_vec;

endmodule
`default_nettype wire
